// File: rtl/imem_loader.sv
// Framed byte-stream program loader for the RISC8 instruction memory.
// Parses SYNC/ADDR/LEN/payload/CHK frames and holds the core in reset until a good frame lands.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              hold_q, hold_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              accept;
  logic [7:0]        chkTotal;

  assign accept   = in_valid & ready_q;
  assign chkTotal = sum_q + in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      hold_q  <= 1'b1;
      base_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    base_d  = base_q;
    idx_d   = idx_q;
    count_d = count_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = S_ADDR;
          hold_d  = 1'b1;
        end
      end
      S_ADDR: begin
        if (accept) begin
          base_d  = ADDR_W'(in_data);
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            state_d = S_ERR;
          end else begin
            count_d = in_data;
            sum_d   = 8'h00;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      // Writes are registered, so they trail the accepted byte by one cycle.
      S_DATA: begin
        if (accept) begin
          sum_d   = sum_q + in_data;
          we_d    = 1'b1;
          addr_d  = base_q + idx_q;
          wdata_d = in_data;
          idx_d   = idx_q + 1'b1;
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (chkTotal == 8'h00) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered so in_ready stays low through reset and rises on the first clock after release.
  assign ready_d = (state_d != S_DONE) && (state_d != S_ERR);

  assign in_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign checksum  = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model, monitor queues
// of observed writes and pulses, randomized handshake gaps and payloads.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Monitor: free-running record of every write and pulse, sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] gotW[$];
  int          gotCyc[$];
  int          doneSeen = 0;
  int          errSeen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      gotW.push_back({mem_addr, mem_wdata});
      gotCyc.push_back(cyc);
    end
    if (done === 1'b1) doneSeen++;
    if (err === 1'b1) errSeen++;
  end

  // Reference model state: expected writes of the current stream plus persistent outputs.
  logic [7:0]  frameQ[$];
  logic [15:0] expW[$];
  int          expDone;
  int          expErr;
  logic [7:0]  expChecksum = 8'h00;
  logic        expHold = 1'b1;

  task automatic modelStream();
    int i;
    int base;
    int len;
    int sum;
    i = 0;
    expW.delete();
    expDone = 0;
    expErr = 0;
    while (i < frameQ.size()) begin
      if (frameQ[i] != 8'hA5) begin
        i++;
      end else begin
        expHold = 1'b1;
        if (i + 2 >= frameQ.size()) break;
        base = int'(frameQ[i+1]);
        len  = int'(frameQ[i+2]);
        i += 3;
        if (len == 0) begin
          expErr++;
        end else begin
          if (i + len >= frameQ.size()) break;
          sum = 0;
          for (int k = 0; k < len; k++) begin
            expW.push_back({8'((base + k) % 256), frameQ[i+k]});
            sum += int'(frameQ[i+k]);
          end
          expChecksum = 8'(sum % 256);
          if ((sum + int'(frameQ[i+len])) % 256 == 0) begin
            expDone++;
            expHold = 1'b0;
          end else begin
            expErr++;
          end
          i += len + 1;
        end
      end
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    int waited;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      assertions++;
      failures++;
      $display("[TB] FAIL handshake timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic sendStream(input int maxGap);
    foreach (frameQ[i]) sendByte(frameQ[i], maxGap);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset in_ready: got %b required 0", in_ready); end
    assertions++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset mem_we: got %b required 0", mem_we); end
    assertions++; if (mem_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset mem_addr: got %h required 00", mem_addr); end
    assertions++; if (mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL reset mem_wdata: got %h required 00", mem_wdata); end
    assertions++; if (cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL reset cpu_hold: got %b required 1", cpu_hold); end
    assertions++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL reset pulses: got done=%b err=%b required 0/0", done, err); end
    assertions++; if (checksum !== 8'h00) begin failures++; $display("[TB] FAIL reset checksum: got %h required 00", checksum); end
    reset = 1'b1;
    #1;
    assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL release in_ready early: got %b required 0", in_ready); end
    @(negedge clk);
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_good_frame();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    modelStream();
    sendStream(0);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL good write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL good write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    for (int k = 1; k < nW; k++) begin
      assertions++; if (gotCyc[w0+k] - gotCyc[w0+k-1] != 1) begin failures++; $display("[TB] FAIL good write spacing %0d: got %0d required 1", k, gotCyc[w0+k] - gotCyc[w0+k-1]); end
    end
    assertions++; if (doneSeen - d0 != expDone) begin failures++; $display("[TB] FAIL good done count: got %0d required %0d", doneSeen - d0, expDone); end
    assertions++; if (errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL good err count: got %0d required %0d", errSeen - e0, expErr); end
    assertions++; if (checksum !== expChecksum) begin failures++; $display("[TB] FAIL good checksum: got %h required %h", checksum, expChecksum); end
    assertions++; if (cpu_hold !== expHold) begin failures++; $display("[TB] FAIL good cpu_hold: got %b required %b", cpu_hold, expHold); end
  endtask

  task automatic test_bad_chk();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFB};
    modelStream();
    sendStream(0);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL badchk write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL badchk write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    assertions++; if (doneSeen - d0 != expDone) begin failures++; $display("[TB] FAIL badchk done count: got %0d required %0d", doneSeen - d0, expDone); end
    assertions++; if (errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL badchk err count: got %0d required %0d", errSeen - e0, expErr); end
    assertions++; if (cpu_hold !== expHold) begin failures++; $display("[TB] FAIL badchk cpu_hold: got %b required %b", cpu_hold, expHold); end
  endtask

  task automatic test_garbage();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'h00, 8'hFF, 8'h13};
    modelStream();
    sendStream(0);
    assertions++; if (gotW.size() != w0) begin failures++; $display("[TB] FAIL garbage writes: got %0d required 0", gotW.size() - w0); end
    assertions++; if (in_ready !== 1'b1 || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL garbage idle: got ready=%b hold=%b required 1/%b", in_ready, cpu_hold, expHold); end
    frameQ = {8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    modelStream();
    sendStream(0);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL garbage write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL garbage write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL garbage pulses: got done=%0d err=%0d required %0d/%0d", doneSeen - d0, errSeen - e0, expDone, expErr); end
    assertions++; if (checksum !== expChecksum || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL garbage status: got chk=%h hold=%b required %h/%b", checksum, cpu_hold, expChecksum, expHold); end
  endtask

  task automatic test_wrap();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    modelStream();
    sendStream(0);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL wrap write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL wrap write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL wrap pulses: got done=%0d err=%0d required %0d/%0d", doneSeen - d0, errSeen - e0, expDone, expErr); end
    assertions++; if (checksum !== expChecksum) begin failures++; $display("[TB] FAIL wrap checksum: got %h required %h", checksum, expChecksum); end
  endtask

  task automatic test_len_zero();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'h00, 8'h00, 8'hA5, 8'h20, 8'h01, 8'h7F, 8'h81};
    modelStream();
    for (int i = 0; i < 3; i++) sendByte(frameQ[i], 0);
    assertions++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL lenzero err after LEN: got %b required 1", err); end
    assertions++; if (gotW.size() != w0) begin failures++; $display("[TB] FAIL lenzero writes: got %0d required 0", gotW.size() - w0); end
    for (int i = 3; i < frameQ.size(); i++) sendByte(frameQ[i], 0);
    repeat (4) @(negedge clk);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL lenzero write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL lenzero write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL lenzero pulses: got done=%0d err=%0d required %0d/%0d", doneSeen - d0, errSeen - e0, expDone, expErr); end
    assertions++; if (checksum !== expChecksum || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL lenzero status: got chk=%h hold=%b required %h/%b", checksum, cpu_hold, expChecksum, expHold); end
  endtask

  task automatic test_random_gaps();
    int w0, d0, e0, nW, len, sum;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
      len = int'($urandom_range(12, 1));
      frameQ = {8'hA5, 8'($urandom), 8'(len)};
      sum = 0;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        frameQ.push_back(b);
        sum += int'(b);
      end
      b = 8'(256 - (sum % 256));
      if ($urandom_range(3, 0) == 0) b = b + 8'd1;
      frameQ.push_back(b);
      modelStream();
      sendStream(3);
      nW = gotW.size() - w0;
      assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL random%0d write count: got %0d required %0d", it, nW, expW.size()); end
      foreach (expW[k]) if (k < nW) begin
        assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL random%0d write %0d: got %h required %h", it, k, gotW[w0+k], expW[k]); end
      end
      assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL random%0d pulses: got done=%0d err=%0d required %0d/%0d", it, doneSeen - d0, errSeen - e0, expDone, expErr); end
      assertions++; if (checksum !== expChecksum || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL random%0d status: got chk=%h hold=%b required %h/%b", it, checksum, cpu_hold, expChecksum, expHold); end
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0, e0, nW;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'h30, 8'h02, 8'h01, 8'h01, 8'hFE, 8'hA5, 8'h31, 8'h01, 8'h55, 8'hAB};
    modelStream();
    sendStream(0);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL b2b write count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL b2b write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    // Payload-to-payload distance: CHK, DONE stall, SYNC, ADDR, LEN, then the next data byte.
    if (nW == 3) begin
      assertions++; if (gotCyc[w0+2] - gotCyc[w0+1] != 6) begin failures++; $display("[TB] FAIL b2b frame spacing: got %0d required 6", gotCyc[w0+2] - gotCyc[w0+1]); end
    end
    assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL b2b pulses: got done=%0d err=%0d required %0d/%0d", doneSeen - d0, errSeen - e0, expDone, expErr); end
    assertions++; if (checksum !== expChecksum || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL b2b status: got chk=%h hold=%b required %h/%b", checksum, cpu_hold, expChecksum, expHold); end
  endtask

  task automatic test_reset_midframe();
    int w0, d0, e0, nW;
    logic [7:0] partial[$];
    partial = {8'hA5, 8'h10, 8'h04, 8'hAA, 8'hBB};
    foreach (partial[i]) sendByte(partial[i], 0);
    reset = 1'b0;
    #1;
    assertions++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin failures++; $display("[TB] FAIL midreset write port: got we=%b addr=%h data=%h required 0/00/00", mem_we, mem_addr, mem_wdata); end
    assertions++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("[TB] FAIL midreset control: got ready=%b hold=%b required 0/1", in_ready, cpu_hold); end
    assertions++; if (done !== 1'b0 || err !== 1'b0 || checksum !== 8'h00) begin failures++; $display("[TB] FAIL midreset status: got done=%b err=%b chk=%h required 0/0/00", done, err, checksum); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    w0 = gotW.size();
    repeat (5) @(negedge clk);
    assertions++; if (gotW.size() != w0) begin failures++; $display("[TB] FAIL midreset stray writes: got %0d required 0", gotW.size() - w0); end
    expHold = 1'b1;
    expChecksum = 8'h00;
    w0 = gotW.size(); d0 = doneSeen; e0 = errSeen;
    frameQ = {8'hA5, 8'h40, 8'h02, 8'h12, 8'h34, 8'hBA};
    modelStream();
    sendStream(2);
    nW = gotW.size() - w0;
    assertions++; if (nW != expW.size()) begin failures++; $display("[TB] FAIL midreset reload count: got %0d required %0d", nW, expW.size()); end
    foreach (expW[k]) if (k < nW) begin
      assertions++; if (gotW[w0+k] !== expW[k]) begin failures++; $display("[TB] FAIL midreset reload write %0d: got %h required %h", k, gotW[w0+k], expW[k]); end
    end
    assertions++; if (doneSeen - d0 != expDone || errSeen - e0 != expErr) begin failures++; $display("[TB] FAIL midreset reload pulses: got done=%0d err=%0d required %0d/%0d", doneSeen - d0, errSeen - e0, expDone, expErr); end
    assertions++; if (checksum !== expChecksum || cpu_hold !== expHold) begin failures++; $display("[TB] FAIL midreset reload status: got chk=%h hold=%b required %h/%b", checksum, cpu_hold, expChecksum, expHold); end
  endtask

  initial begin
    #1 reset = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_garbage();
    test_wrap();
    test_len_zero();
    test_random_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Hardware program loader for the RISC8 core. It receives a framed byte stream over a valid/ready handshake and writes the payload into the core's 8-bit instruction memory. It holds the core in reset until a frame with a good checksum has been fully written. It is the in-silicon counterpart of the bench's direct instruction-memory preload, and the write-side producer that the core's fetch stage reads from.

Parameters:
ADDR_W, 8, instruction memory address width (256 locations)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  source presents a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte; transfer happens when in_valid & in_ready at posedge
mem_we  output  1  instruction memory write strobe, one cycle per payload byte
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  write data
cpu_hold  output  1  drives the core's reset; 1 = core held
done  output  1  one-cycle pulse on a successful load
err  output  1  one-cycle pulse on a rejected frame
checksum  output  8  running payload sum; holds the last frame's value after DONE/ERR

Behaviour:
- Reset (reset=0, async): state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, checksum=0, count=0. On the first clock after release, in_ready=1.
- Frame format: SYNC_BYTE, START_ADDR, LEN (1..255), LEN payload bytes, CHK. The frame is good when (sum of payload + CHK) mod 256 == 0.
- FSM states: IDLE, ADDR, LEN, DATA, CHK, DONE, ERR. Each transition happens only on an accepted byte, except the DONE and ERR exits.
  - IDLE: an accepted byte equal to SYNC_BYTE moves to ADDR; any other byte is discarded silently.
  - ADDR: latch base address; go to LEN.
  - LEN: LEN==0 goes to ERR; otherwise latch count=LEN, clear checksum, go to DATA.
  - DATA: each accepted byte adds to checksum (mod 256) and issues a write. Move to CHK after the LEN-th byte.
  - CHK: checksum+byte==0 goes to DONE; otherwise goes to ERR.
  - DONE: done=1 and cpu_hold=0 for one cycle, then IDLE. cpu_hold stays 0 until the next accepted SYNC_BYTE.
  - ERR: err=1 for one cycle, then IDLE. cpu_hold stays 1.
- in_ready: 1 in IDLE, ADDR, LEN, DATA and CHK; 0 in DONE and ERR. Gaps in in_valid stall the FSM with no state change.
- cpu_hold rises in the same cycle a SYNC_BYTE is accepted in IDLE, so the core is held before any memory write.
- Write timing:
  - mem_we, mem_addr and mem_wdata are registered and valid one cycle after byte acceptance in DATA.
  - mem_addr = base + index, with index starting at 0, computed mod 2^ADDR_W so 0xFF wraps to 0x00.
  - mem_we is 0 in every other cycle.
- Partially written memory after ERR is not rolled back. Software reloads the image.
- Reset mid-frame aborts immediately: no further writes, cpu_hold=1, and the FSM returns to IDLE.
- Back-to-back frames are allowed. The earliest next SYNC_BYTE acceptance is the cycle after the DONE/ERR pulse.

Test Plan:
- A5,10,03,01,02,03,FA with in_valid held high → writes 01@0x10, 02@0x11, 03@0x12 on three consecutive mem_we cycles; done pulses once; cpu_hold falls; checksum=06.
- Same frame with CHK=FB → three writes occur; err pulses; done stays 0; cpu_hold stays 1.
- Bytes 00,FF,13 before the frame in the first scenario → no writes and the state stays IDLE; then identical behaviour to the first scenario.
- A5,FE,03,11,22,33,9A → writes at 0xFE, 0xFF, 0x00 (wrap); done pulses.
- A5,00,00 → err pulses right after the LEN byte; no mem_we; the next A5 is accepted.
- Frame split with random in_valid gaps (0–3 cycles) → same writes and order as with no gaps.
- Assert reset low after the second payload byte → outputs at reset values within the same cycle; no further writes; after release, a fresh good frame loads correctly.
